// File: rtl/arb_mux.sv
// arb_mux: N-channel, WIDTH-bit registered multiplexer with valid/ready on every
// input and on the output, arbitrating by external select, fixed priority or round-robin.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] d,
  input  logic [N-1:0]       d_valid,
  output logic [N-1:0]       d_ready,
  input  logic [SEL_W-1:0]   s,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  input  logic               y_ready,
  output logic [SEL_W-1:0]   y_chan
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] grant;
  logic             req;
  logic             space;
  logic             xfer;
  int unsigned      rr_idx;

  always_comb begin
    grant  = '0;
    req    = 1'b0;
    rr_idx = 0;
    if (MODE == 0) begin
      grant = s;
      // A select beyond N-1 (non power-of-two N) never forms a request.
      if (int'(s) < N) req = d_valid[s];
    end else if (MODE == 1) begin
      // Scan downward so the lowest valid index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
        if (d_valid[i]) begin
          grant = i[SEL_W-1:0];
          req   = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        rr_idx = (int'(ptr_q) + k) % N;
        if (d_valid[rr_idx]) begin
          grant = rr_idx[SEL_W-1:0];
          req   = 1'b1;
        end
      end
    end
  end

  // A new word may load on the same edge the old one drains.
  assign space = !valid_q || y_ready;
  assign xfer  = req && space && !reset;

  always_comb begin
    d_ready = '0;
    if (xfer) d_ready[grant] = 1'b1;
  end

  always_comb begin
    y_d     = y_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      y_d     = d[int'(grant)*WIDTH +: WIDTH];
      chan_d  = grant;
      valid_d = 1'b1;
      if (MODE == 2) ptr_d = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end else if (y_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values; reset clears the data register too so y reads 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q     <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      y_q     <= y_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_chan  = chan_q;
  assign y_valid = valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: one instance per arbitration mode sharing the stimulus.
module tb_arb_mux;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  localparam logic [31:0] A = 32'hAAAA_AAAA;
  localparam logic [31:0] B = 32'hBBBB_BBBB;
  localparam logic [31:0] C = 32'hCCCC_CCCC;
  localparam logic [31:0] D = 32'hDDDD_DDDD;

  logic               clk = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] d;
  logic [N-1:0]       d_valid;
  logic [SEL_W-1:0]   s;
  logic               y_ready;

  logic [N-1:0]     rdy0, rdy1, rdy2;
  logic [WIDTH-1:0] y0, y1, y2;
  logic             v0, v1, v2;
  logic [SEL_W-1:0] c0, c1, c2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(0)) u_m0 (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(rdy0), .s(s),
    .y(y0), .y_valid(v0), .y_ready(y_ready), .y_chan(c0));
  arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(1)) u_m1 (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(rdy1), .s(s),
    .y(y1), .y_valid(v1), .y_ready(y_ready), .y_chan(c1));
  arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(2)) u_m2 (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(rdy2), .s(s),
    .y(y2), .y_valid(v2), .y_ready(y_ready), .y_chan(c2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between edges (caller sits at posedge+1).
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    d       = {D, C, B, A};
    d_valid = '0;
    s       = '0;
    y_ready = 1'b0;
    #12;
    check("rst_y",      y2,   0);
    check("rst_valid",  v2,   0);
    check("rst_chan",   c2,   0);
    check("rst_dready", rdy2, 0);
    reset = 1'b0;
    tick();

    // MODE 0: external select stepping 0..3
    d_valid = 4'b1111;
    y_ready = 1'b1;
    s = 2'd0; #1;
    check("m0_dready_s0", rdy0, 4'b0001);
    tick(); check("m0_y_A", y0, A); check("m0_chan0", c0, 0); check("m0_valid", v0, 1);
    s = 2'd1;
    tick(); check("m0_y_B", y0, B); check("m0_chan1", c0, 1);
    s = 2'd2;
    tick(); check("m0_y_C", y0, C); check("m0_chan2", c0, 2);
    s = 2'd3;
    tick(); check("m0_y_D", y0, D); check("m0_chan3", c0, 3);

    // MODE 0: select changes during a stall are ignored
    pulse_reset();
    y_ready = 1'b0;
    s = 2'd2;
    tick(); check("m0_stall_load", y0, C);
    s = 2'd3; #1;
    check("m0_stall_dready", rdy0, 0);
    tick(); check("m0_stall_hold_y", y0, C); check("m0_stall_hold_chan", c0, 2);
    y_ready = 1'b1;
    s = 2'd1;
    tick(); check("m0_resume_y", y0, B); check("m0_resume_chan", c0, 1);

    // MODE 1: fixed priority
    pulse_reset();
    d_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("m1_y_A", y1, A);
      check("m1_chan0", c1, 0);
    end
    d_valid = 4'b1110;
    tick(); check("m1_y_B", y1, B); check("m1_chan1", c1, 1);

    // MODE 2: round-robin with all channels valid, pointer wraps 3 -> 0
    pulse_reset();
    d_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("m2_dready_onehot", rdy2, 4'b0001 << (k % 4));
      tick();
      check("m2_rr_chan", c2, k % 4);
    end
    // Only channels 1 and 3 valid: pointer is 1 here, so 1,3,1,3
    d_valid = 4'b1010;
    tick(); check("m2_alt_1a", c2, 1); check("m2_alt_y_B", y2, B);
    tick(); check("m2_alt_3a", c2, 3); check("m2_alt_y_D", y2, D);
    tick(); check("m2_alt_1b", c2, 1);
    tick(); check("m2_alt_3b", c2, 3);

    // Backpressure in MODE 2
    pulse_reset();
    d_valid = 4'b0011;
    y_ready = 1'b0;
    tick(); check("bp_load_A", y2, A);
    for (int k = 0; k < 3; k++) begin
      check("bp_dready", rdy2, 0);
      tick();
      check("bp_hold_y", y2, A);
      check("bp_hold_valid", v2, 1);
    end
    y_ready = 1'b1; #1;
    check("bp_release_dready", rdy2, 4'b0010);
    tick();
    check("bp_noBubble_y", y2, B); check("bp_noBubble_valid", v2, 1); check("bp_chan", c2, 1);

    // Empty drain: single word C then no requests
    d_valid = 4'b0100;
    tick(); check("drain_load_C", y2, C); check("drain_valid1", v2, 1);
    d_valid = 4'b0000;
    tick(); check("drain_valid0", v2, 0); check("drain_y_hold", y2, C); check("drain_chan_hold", c2, 2);

    // Asynchronous reset with y=B, ptr=2, y_valid=1
    pulse_reset();
    d_valid = 4'b1111;
    tick();
    tick(); check("ar_pre_y_B", y2, B); check("ar_pre_valid", v2, 1);
    y_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("ar_y",      y2,   0);
    check("ar_valid",  v2,   0);
    check("ar_chan",   c2,   0);
    check("ar_dready", rdy2, 0);
    reset = 1'b0;
    y_ready = 1'b1;
    #1;
    check("ar_first_grant", rdy2, 4'b0001);
    tick(); check("ar_first_chan", c2, 0); check("ar_first_y", y2, A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output. It is the successor to the combinational mux2/mux4 pair. It selects one source per cycle by one of three modes: external select, fixed priority or round-robin. The selected word is registered into a one-entry output stage. It sits between producers (register file ports, ALU/memory result paths) and a single downstream consumer that may stall.

## Interface

- WIDTH, 32, data width per channel (≥1)
- N, 4, number of input channels (≥2); SEL_W = $clog2(N) is a localparam
- MODE, 0, arbitration mode:
  - 0 = external select `s`
  - 1 = fixed priority, channel 0 highest
  - 2 = round-robin

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- d  input  N*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- d_valid  input  N  per-channel valid
- d_ready  output  N  per-channel ready; at most one bit set per cycle
- s  input  SEL_W  channel select; used only in MODE 0
- y  output  WIDTH  registered output data
- y_valid  output  1  output register holds a word
- y_ready  input  1  consumer accepts y this cycle
- y_chan  output  SEL_W  index of the channel that produced y

## Operation

- Output stage is one register: y, y_chan, y_valid.
- `space` = !y_valid || y_ready. A new word may load in the same cycle the old word drains.
- Grant `g` is combinational from the current inputs:
  - MODE 0: g = s. A request exists only if d_valid[s]; other channels are never granted.
  - MODE 1: g = lowest index i with d_valid[i].
  - MODE 2: g = first i with d_valid[i], scanning ptr, ptr+1, … N-1, 0, … ptr-1 (modulo N).
- Request exists and space → d_ready[g] = 1; all other d_ready bits are 0.
- No request, or no space → d_ready = 0.
- d_ready does not depend on d_valid of non-granted channels. It may depend on d_valid[g] only through grant selection.
- Transfer (d_valid[g] && d_ready[g]) at a clock edge:
  - y ← channel g data, y_chan ← g, y_valid ← 1.
  - MODE 2 only: ptr ← (g+1) mod N, wrapping N-1 → 0.
- y_valid && y_ready with no transfer → y_valid ← 0. y and y_chan hold their last values.
- y_valid && !y_ready → y, y_chan, y_valid hold. d_ready = 0 (stall propagates).
- ptr changes only on a transfer. It is unused and stays 0 in MODES 0 and 1.
- Data is never dropped or duplicated: each accepted input word appears on y exactly once.

## Timing

- Reset (asynchronous, at any time including mid-transfer):
  - y = 0, y_chan = 0, y_valid = 0, ptr = 0.
  - d_ready is all zeros while reset is high.
  - Any in-flight word is discarded.
- Latency: input accepted at edge k → y_valid = 1 with that data after edge k.
- Consumer handshake completes at edge k+1 or later.
- Throughput is one word per cycle when y_ready is held high.
- Once y_valid is high, y and y_chan are stable until the cycle y_ready is sampled high.
- Simultaneous drain and load at one edge: the new word replaces the old with no bubble; y_valid stays 1.
- MODE 0: `s` changing while y_valid && !y_ready has no effect until space returns.
- First cycle after reset release: ptr = 0, so channel 0 has top round-robin priority.

## Test plan

- MODE 0, WIDTH=32, N=4:
  - d = {D,C,B,A} (hex), all valid, y_ready=1, s stepped 0,1,2,3 once per cycle.
  - Required: y = A,B,C,D on consecutive cycles, one cycle after each select; y_chan = 0,1,2,3.
- MODE 1, all four valid, y_ready=1 for 4 cycles:
  - Required: y = A every cycle with y_chan = 0.
  - Then drop d_valid[0]: next y = B.
- MODE 2, all four valid continuously, y_ready=1:
  - Required: grant order 0,1,2,3,0, ptr wraps 3→0, d_ready one-hot each cycle.
  - With only channels 1 and 3 valid: alternation 1,3,1,3.
- Backpressure, MODE 2:
  - Load A, hold y_ready=0 for 3 cycles.
  - Required: y=A and y_valid=1 held, d_ready=0 throughout.
  - Raise y_ready: A completes that cycle and B loads on the same edge (no bubble).
- Empty drain: single word C accepted, then no d_valid.
  - Required: y_valid=1 for one cycle, y_ready=1 clears it, y stays C.
- Asynchronous reset mid-stream: assert reset between edges while y_valid=1, y=B, ptr=2.
  - Required: y=0, y_valid=0, y_chan=0, d_ready=0 immediately, with no clock edge.
  - After release, first grant goes to channel 0.
